// File: rtl/xor_unit_arbiter.sv
// Round-robin scheduler that shares one external bitwise XOR unit between two
// valid/ready requesters: accept, execute, then hold the response until taken.
module xor_unit_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  output logic             req0_ready,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [N-1:0]     resp0_data,
  input  logic             req1_valid,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             req1_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [N-1:0]     resp1_data,
  output logic [N-1:0]     xu_a,
  output logic [N-1:0]     xu_b,
  input  logic [N-1:0]     xu_c,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nx;
  logic           prio;
  logic           gnt;
  logic           sel;
  logic           acc;
  logic           done;
  logic [N-1:0]   op_a, op_b, res;
  logic [N-1:0]   last0, last1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    sel      = prio;
    if (req0_valid && !req1_valid)      sel = 1'b0;
    else if (req1_valid && !req0_valid) sel = 1'b1;

    // Ready is a function of the live valid, so a requester that drops valid
    // before acceptance simply loses the grant without touching any state.
    req0_ready  = rst_n && (state == IDLE) && req0_valid && !sel;
    req1_ready  = rst_n && (state == IDLE) && req1_valid &&  sel;
    acc         = req0_ready || req1_ready;

    resp0_valid = (state == RESP) && !gnt;
    resp1_valid = (state == RESP) &&  gnt;
    done        = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

    case (state)
      IDLE:    if (acc)  state_nx = EXEC;
      EXEC:              state_nx = RESP;
      RESP:    if (done) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      gnt      <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      last0    <= '0;
      last1    <= '0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        op_a <= sel ? req1_a : req0_a;
        op_b <= sel ? req1_b : req0_b;
        gnt  <= sel;
      end
      if (state == EXEC) res <= xu_c;
      if (done) begin
        prio     <= ~gnt;
        op_count <= op_count + CNT_W'(1);
        if (gnt) last1 <= res;
        else     last0 <= res;
      end
    end
  end

  assign xu_a = op_a;
  assign xu_b = op_b;
  assign busy = (state != IDLE);

  // A non-granted port keeps showing the last result it actually consumed.
  assign resp0_data = resp0_valid ? res : last0;
  assign resp1_data = resp1_valid ? res : last1;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Self-checking bench for xor_unit_arbiter: vector table, scoreboard monitor
// and hand-written sequences for fairness, back-pressure and mid-op reset.
module tb_xor_unit_arbiter;
  localparam int N     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [N-1:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready;
  logic             resp0_valid, resp1_valid;
  logic             resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [N-1:0]     resp0_data, resp1_data;
  logic [N-1:0]     xu_a, xu_b, xu_c;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  assign xu_c = xu_a ^ xu_b;

  xor_unit_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .xu_a(xu_a), .xu_b(xu_b), .xu_c(xu_c),
    .busy(busy), .op_count(op_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic       id;
    logic [7:0] d;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] last_d [2];

  task automatic sb_pop(input logic id, input logic [7:0] d);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_spurious: got resp id %0d data %0h expected no response at %0t", id, d, $time);
    end else begin
      e = sb_q.pop_front();
      check("sb_id", 32'(id), 32'(e.id));
      check("sb_data", 32'(d), 32'(e.d));
      last_d[e.id] = e.d;
    end
  endtask

  // Scoreboard: expected results come from the bench's own view of the operands.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      last_d[0] = '0;
      last_d[1] = '0;
    end else begin
      if (resp0_valid && resp0_ready) sb_pop(1'b0, resp0_data);
      if (resp1_valid && resp1_ready) sb_pop(1'b1, resp1_data);
      if (req0_valid && req0_ready) sb_q.push_back('{id: 1'b0, d: req0_a ^ req0_b});
      if (req1_valid && req1_ready) sb_q.push_back('{id: 1'b1, d: req1_a ^ req1_b});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  typedef struct {
    logic       v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic       exp_g;
    logic [7:0] exp_d;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One transaction from IDLE with both response channels ready.
  task automatic run_vec(input vec_t v);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(negedge clk);
    check("grant_req0_ready", 32'(req0_ready), 32'(!v.exp_g));
    check("grant_req1_ready", 32'(req1_ready), 32'(v.exp_g));
    step();
    idle_inputs();
    @(negedge clk);
    check("exec_busy", 32'(busy), 1);
    check("exec_no_resp", {resp1_valid, resp0_valid}, 0);
    step();
    @(negedge clk);
    check("resp_valid", {resp1_valid, resp0_valid}, v.exp_g ? 2 : 1);
    check("resp_data", 32'(v.exp_g ? resp1_data : resp0_data), 32'(v.exp_d));
    check("other_data_hold", 32'(v.exp_g ? resp0_data : resp1_data), 32'(last_d[v.exp_g ? 0 : 1]));
    step();
    @(negedge clk);
    check("done_busy", 32'(busy), 0);
    check("op_count", 32'(op_count), 32'(v.exp_cnt));
    step();
  endtask

  initial begin
    vecs[0] = '{v0:1'b1, v1:1'b0, a0:8'hF0, b0:8'h3C, a1:8'h00, b1:8'h00, exp_g:1'b0, exp_d:8'hCC, exp_cnt:2'd1};
    vecs[1] = '{v0:1'b0, v1:1'b1, a0:8'h00, b0:8'h00, a1:8'h12, b1:8'h34, exp_g:1'b1, exp_d:8'h26, exp_cnt:2'd2};
    vecs[2] = '{v0:1'b1, v1:1'b1, a0:8'h55, b0:8'hFF, a1:8'hA5, b1:8'h0F, exp_g:1'b0, exp_d:8'hAA, exp_cnt:2'd3};
    vecs[3] = '{v0:1'b0, v1:1'b1, a0:8'h00, b0:8'h00, a1:8'hA5, b1:8'h0F, exp_g:1'b1, exp_d:8'hAA, exp_cnt:2'd0};
    vecs[4] = '{v0:1'b1, v1:1'b1, a0:8'h6B, b0:8'h0D, a1:8'h81, b1:8'h7E, exp_g:1'b0, exp_d:8'h66, exp_cnt:2'd1};
    vecs[5] = '{v0:1'b1, v1:1'b1, a0:8'h3C, b0:8'h3C, a1:8'hC3, b1:8'h00, exp_g:1'b1, exp_d:8'hC3, exp_cnt:2'd2};

    // Reset: a pending valid must not see ready while rst_n is low.
    rst_n = 1'b0;
    req0_valid = 1'b1;
    step();
    @(negedge clk);
    check("rst_req0_ready_gated", 32'(req0_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
    check("rst_resp_data", {resp1_data, resp0_data}, 0);
    step();
    rst_n = 1'b1;
    idle_inputs();

    // Table: single requests, simultaneous requests and op_count wrap 1,2,3,0,1,2.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both continuously valid: grants strictly alternate starting at 0.
    begin
      int         acc_n;
      logic [5:0] order;
      acc_n = 0;
      order = '0;
      do_reset();
      req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h44; req1_b = 8'h88;
      req0_valid = 1'b1; req1_valid = 1'b1;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      for (int c = 0; c < 40 && acc_n < 6; c++) begin
        @(negedge clk);
        if (req0_ready) begin order[acc_n] = 1'b0; acc_n++; end
        else if (req1_ready) begin order[acc_n] = 1'b1; acc_n++; end
        if (acc_n < 6) step();
      end
      step();
      idle_inputs();
      check("alt_accepts", 32'(acc_n), 6);
      for (int i = 0; i < 6; i++) check("alt_order", 32'(order[i]), 32'(i % 2));
      repeat (3) step();
      @(negedge clk);
      check("alt_op_count", 32'(op_count), 2);
      step();
    end

    // Back-pressure on response 1 for 5 cycles while requester 0 waits.
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    req1_a = 8'h9A; req1_b = 8'h5F; req1_valid = 1'b1;
    @(negedge clk);
    check("bp_accept", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1;
    @(negedge clk);
    check("bp_exec_req0_ready", 32'(req0_ready), 0);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_resp1_valid", 32'(resp1_valid), 1);
      check("bp_resp1_data", 32'(resp1_data), 32'h C5);
      check("bp_busy", 32'(busy), 1);
      check("bp_req0_ready", 32'(req0_ready), 0);
      step();
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(resp1_valid), 1);
    step();
    @(negedge clk);
    check("bp_idle_busy", 32'(busy), 0);
    check("bp_next_accept", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("bp_op_count", 32'(op_count), 2);
    step();

    // Reset while in EXEC drops the operation.
    do_reset();
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_a = 8'h77; req0_b = 8'h11; req0_valid = 1'b1;
    @(negedge clk);
    check("mr_accept", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mr_no_resp", {resp1_valid, resp0_valid}, 0);
      check("mr_idle", 32'(busy), 0);
      step();
    end
    check("mr_op_count", 32'(op_count), 0);
    req1_a = 8'h0F; req1_b = 8'h0C; req1_valid = 1'b1;
    @(negedge clk);
    check("mr_req1_accept", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check("mr_resp1_valid", 32'(resp1_valid), 1);
    check("mr_resp1_data", 32'(resp1_data), 32'h03);
    step();
    @(negedge clk);
    check("mr_op_count_after", 32'(op_count), 1);
    step();

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
